// File: rtl/instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline that packs format, registers and immediate
// into an instruction word. Define IMM_CHECK_EN to flag immediates the chosen format cannot represent.
`timescale 1ns/1ps
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    input  logic                 addr_clear,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [2:0] {
        FMT_OPIMM, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_JAL, FMT_JALR, FMT_LUI, FMT_AUIPC
    } fmt_e;

    typedef struct packed {
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } req_t;

    req_t              a_req;
    logic              a_valid;
    logic              a_take;
    logic              b_load;
    logic              hs;
    logic [31:0]       im;
    logic [31:0]       enc;
    logic [ADDR_W-1:0] addr_q;

    // Stage A may refill in the same cycle it drains into stage B.
    assign in_ready = !a_valid || !out_valid || out_ready;
    assign a_take   = in_valid && in_ready;
    assign b_load   = a_valid && (!out_valid || out_ready);
    assign hs       = out_valid && out_ready;
    assign out_addr = addr_q;
    assign im       = a_req.imm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_req   <= '0;
        end else if (a_take) begin
            a_valid <= 1'b1;
            a_req   <= '{fmt: fmt_e'(in_fmt), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         f3: in_funct3, imm: in_imm};
        end else if (b_load) begin
            a_valid <= 1'b0;
        end
    end

    always_comb begin
        enc = '0;
        case (a_req.fmt)
            FMT_OPIMM:  enc = {im[11:0], a_req.rs1, a_req.f3, a_req.rd, 7'b0010011};
            FMT_LOAD:   enc = {im[11:0], a_req.rs1, a_req.f3, a_req.rd, 7'b0000011};
            FMT_STORE:  enc = {im[11:5], a_req.rs2, a_req.rs1, a_req.f3, im[4:0], 7'b0100011};
            FMT_BRANCH: enc = {im[12], im[10:5], a_req.rs2, a_req.rs1, a_req.f3,
                               im[4:1], im[11], 7'b1100011};
            FMT_JAL:    enc = {im[20], im[10:1], im[11], im[19:12], a_req.rd, 7'b1101111};
            FMT_JALR:   enc = {im[11:0], a_req.rs1, a_req.f3, a_req.rd, 7'b1100111};
            FMT_LUI:    enc = {im[31:12], a_req.rd, 7'b0110111};
            FMT_AUIPC:  enc = {im[31:12], a_req.rd, 7'b0010111};
            default:    enc = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
        end else if (b_load) begin
            out_valid <= 1'b1;
            out_instr <= enc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear beats a concurrent handshake increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             addr_q <= '0;
        else if (addr_clear) addr_q <= '0;
        else if (hs)         addr_q <= addr_q + 1'b1;
    end

`ifdef IMM_CHECK_EN
    logic                 imm_err;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Representable iff the bits above the field's sign bit are a pure sign extension.
    always_comb begin
        imm_err = 1'b0;
        case (a_req.fmt)
            FMT_BRANCH:         imm_err = !(&im[31:12] || ~|im[31:12]) || im[0];
            FMT_JAL:            imm_err = !(&im[31:20] || ~|im[31:20]) || im[0];
            FMT_LUI, FMT_AUIPC: imm_err = |im[11:0];
            default:            imm_err = !(&im[31:11] || ~|im[31:11]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_q <= 1'b0;
        else if (b_load) err_q <= imm_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err_cnt_q <= '0;
        else if (hs && err_q && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign out_err   = err_q;
    assign err_count = err_cnt_q;
`else
    assign out_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder (ADDR_W=2, ERR_CNT_W=2); expectations adapt to IMM_CHECK_EN.
`timescale 1ns/1ps
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_err, addr_clear;
    logic [2:0]  in_fmt, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [1:0]  out_addr, err_count;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
    } item_t;

    instr_encoder #(.ADDR_W(2), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .addr_clear(addr_clear), .err_count(err_count));

    always #5 clk = ~clk;

    function automatic logic [31:0] decode_imm(input logic [31:0] i);
        case (i[6:0])
            7'h23:        return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h6F:        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            7'h37, 7'h17: return {i[31:12], 12'h000};
            default:      return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input logic [2:0] f);
        case (f)
            3'd0:    return 7'h13;
            3'd1:    return 7'h03;
            3'd2:    return 7'h23;
            3'd3:    return 7'h63;
            3'd4:    return 7'h6F;
            3'd5:    return 7'h67;
            3'd6:    return 7'h37;
            default: return 7'h17;
        endcase
    endfunction

    task automatic set_req(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [2:0] f3, input logic [31:0] imm);
        in_fmt = f; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_funct3 = f3; in_imm = imm;
    endtask

    task automatic do_reset;
        in_valid = 0; out_ready = 0; addr_clear = 0;
        set_req(0, 0, 0, 0, 0, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Send one request and collect its word with out_ready held high.
    task automatic xfer(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [2:0] f3, input logic [31:0] imm,
                        input logic clr, output logic [31:0] instr, output logic err,
                        output logic [1:0] addr);
        int n;
        @(posedge clk); #1;
        set_req(f, rd, r1, r2, f3, imm); in_valid = 1; out_ready = 1;
        #1; n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #2; n++; end
        @(posedge clk); #1; in_valid = 0;
        #1; n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL xfer_timeout got out_valid=0 exp=1");
        end
        instr = out_instr; err = out_err; addr = out_addr; addr_clear = clr;
        @(posedge clk); #1; addr_clear = 0;
    endtask

    task automatic test_reset;
        in_valid = 1; out_ready = 1; addr_clear = 0;
        set_req(0, 1, 1, 1, 0, 1);
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        total++; if (out_addr !== 2'd0) begin bad++; $display("FAIL rst_out_addr got=%0d exp=0", out_addr); end
        total++; if (err_count !== 2'd0) begin bad++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        in_valid = 0; rst = 0;
    endtask

    task automatic test_latency;
        do_reset;
        set_req(0, 5, 6, 0, 0, 32'hFFFF_FFFF); in_valid = 1; out_ready = 1;
        @(posedge clk); #1; in_valid = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cycle1_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_cycle2_valid got=%b exp=1", out_valid); end
        total++; if (out_instr !== 32'hFFF30293) begin bad++; $display("FAIL lat_instr got=%h exp=fff30293", out_instr); end
        total++; if (out_addr !== 2'd0) begin bad++; $display("FAIL lat_addr got=%0d exp=0", out_addr); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain_valid got=%b exp=0", out_valid); end
        total++; if (out_addr !== 2'd1) begin bad++; $display("FAIL lat_addr_inc got=%0d exp=1", out_addr); end
    endtask

    task automatic test_formats;
        logic [2:0]  vf [12] = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd4, 3'd0, 3'd3, 3'd2};
        logic [4:0]  vrd[12] = '{5'd5, 5'd1, 5'd10, 5'd31, 5'd7, 5'd1, 5'd3, 5'd4, 5'd0, 5'd1, 5'd0, 5'd0};
        logic [4:0]  vr1[12] = '{5'd6, 5'd7, 5'd2, 5'd2, 5'd1, 5'd5, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  vr2[12] = '{5'd9, 5'd3, 5'd0, 5'd10, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [2:0]  vf3[12] = '{3'd0, 3'd5, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        logic [31:0] vim[12] = '{32'hFFFFFFFF, 32'h00000800, 32'h00000010, 32'hFFFFFFFC,
                                 32'hFFFFFFF8, 32'h00000004, 32'h12345000, 32'hABCDE000,
                                 32'hFFFFFFFE, 32'h00001005, 32'h00000800, 32'h000007E0};
        logic [31:0] vex[12] = '{32'hFFF30293, 32'h001000EF, 32'h01012503, 32'hFEA12E23,
                                 32'hFE208CE3, 32'h004280E7, 32'h123451B7, 32'hABCDE217,
                                 32'hFFFFF06F, 32'h00500093, 32'h000010E3, 32'h7E000023};
        logic [31:0] instr;
        logic        err, exp_err;
        logic [1:0]  addr;
        do_reset;
        for (int k = 0; k < 12; k++) begin
            xfer(vf[k], vrd[k], vr1[k], vr2[k], vf3[k], vim[k], 1'b0, instr, err, addr);
`ifdef IMM_CHECK_EN
            exp_err = (k == 9);
`else
            exp_err = 1'b0;
`endif
            total++; if (instr !== vex[k]) begin bad++; $display("FAIL fmt_instr[%0d] got=%h exp=%h", k, instr, vex[k]); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL fmt_err[%0d] got=%b exp=%b", k, err, exp_err); end
        end
    endtask

    task automatic test_imm_check;
        logic [2:0]  vf [12] = '{3'd3, 3'd3, 3'd0, 3'd0, 3'd2, 3'd5, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd6};
        logic [31:0] vim[12] = '{32'h3, 32'h1000, 32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                 32'hFFFFF000, 32'h00000FFE, 32'h000FFFFE, 32'h00100000, 32'h101, 32'h800};
        logic        vbad[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] instr;
        logic        err, exp_err;
        logic [1:0]  addr, exp_cnt;
        do_reset;
        exp_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            xfer(vf[k], 5'd1, 5'd2, 5'd3, 3'd0, vim[k], 1'b0, instr, err, addr);
`ifdef IMM_CHECK_EN
            exp_err = vbad[k];
`else
            exp_err = 1'b0;
`endif
            if (exp_err && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            total++; if (err !== exp_err) begin bad++; $display("FAIL chk_err[%0d] got=%b exp=%b", k, err, exp_err); end
            total++; if (err_count !== exp_cnt) begin bad++; $display("FAIL chk_count[%0d] got=%0d exp=%0d", k, err_count, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        set_req(0, 1, 0, 0, 0, 1); in_valid = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%b exp=1", in_ready); end
        @(posedge clk); #1; set_req(0, 2, 0, 0, 0, 2);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid1 got=%b exp=0", out_valid); end
        @(posedge clk); #1; set_req(0, 3, 0, 0, 0, 3);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_rdy2 got=%b exp=0", in_ready); end
        total++; if (out_instr !== 32'h00100093) begin bad++; $display("FAIL b2b_hold0 got=%h exp=00100093", out_instr); end
        @(posedge clk); #2;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_rdy3 got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00100093) begin bad++; $display("FAIL b2b_hold1 got=%b/%h exp=1/00100093", out_valid, out_instr); end
        @(posedge clk); #1; out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy4 got=%b exp=1", in_ready); end
        total++; if (out_instr !== 32'h00100093 || out_addr !== 2'd0) begin bad++; $display("FAIL b2b_w0 got=%h@%0d exp=00100093@0", out_instr, out_addr); end
        @(posedge clk); #1; in_valid = 0;
        #1;
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00200113 || out_addr !== 2'd1) begin bad++; $display("FAIL b2b_w1 got=%b %h@%0d exp=1 00200113@1", out_valid, out_instr, out_addr); end
        @(posedge clk); #2;
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00300193 || out_addr !== 2'd2) begin bad++; $display("FAIL b2b_w2 got=%b %h@%0d exp=1 00300193@2", out_valid, out_instr, out_addr); end
        @(posedge clk); #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_addr;
        logic [31:0] instr;
        logic        err;
        logic [1:0]  addr, exp_a;
        do_reset;
        for (int k = 0; k < 5; k++) begin
            xfer(0, 5'(k), 0, 0, 0, 32'(k), 1'b0, instr, err, addr);
            exp_a = 2'(k);
            total++; if (addr !== exp_a) begin bad++; $display("FAIL addr_seq[%0d] got=%0d exp=%0d", k, addr, exp_a); end
        end
        xfer(0, 1, 0, 0, 0, 0, 1'b1, instr, err, addr);
        total++; if (addr !== 2'd1) begin bad++; $display("FAIL addr_pre_clear got=%0d exp=1", addr); end
        total++; if (out_addr !== 2'd0) begin bad++; $display("FAIL addr_clear got=%0d exp=0", out_addr); end
        xfer(0, 1, 0, 0, 0, 0, 1'b0, instr, err, addr);
        total++; if (addr !== 2'd0) begin bad++; $display("FAIL addr_post_clear got=%0d exp=0", addr); end
    endtask

    task automatic test_random;
        item_t      q[$];
        int         sent, got;
        logic [1:0] ea;
        do_reset;
        sent = 0; got = 0; ea = 0;
        fork
            begin
                bit          pending;
                item_t       it;
                logic [31:0] r;
                int          cyc;
                pending = 0; cyc = 0;
                while (sent < 10000 && cyc < 60000) begin
                    @(posedge clk); #1; cyc++;
                    if (!pending) begin
                        it.fmt = 3'($urandom_range(0, 7));
                        r = $urandom;
                        case (it.fmt)
                            3'd3:    it.imm = {{19{r[12]}}, r[12:1], 1'b0};
                            3'd4:    it.imm = {{11{r[20]}}, r[20:1], 1'b0};
                            3'd6,
                            3'd7:    it.imm = {r[31:12], 12'h000};
                            default: it.imm = {{20{r[11]}}, r[11:0]};
                        endcase
                        set_req(it.fmt, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), it.imm);
                        in_valid = 1; pending = 1;
                    end
                    #1;
                    if (in_ready) begin q.push_back(it); pending = 0; sent++; end
                end
                @(posedge clk); #1; in_valid = 0;
            end
            begin
                item_t it;
                int    cyc;
                cyc = 0;
                while (got < 10000 && cyc < 80000) begin
                    @(posedge clk); #1; cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL rnd_spurious got=%h exp=no word", out_instr);
                        end else begin
                            it = q.pop_front();
                            total++; if (decode_imm(out_instr) !== it.imm) begin bad++; $display("FAIL rnd_imm[%0d] got=%h exp=%h", got, decode_imm(out_instr), it.imm); end
                            total++; if (out_instr[6:0] !== opcode_of(it.fmt)) begin bad++; $display("FAIL rnd_op[%0d] got=%h exp=%h", got, out_instr[6:0], opcode_of(it.fmt)); end
                            total++; if (out_addr !== ea) begin bad++; $display("FAIL rnd_addr[%0d] got=%0d exp=%0d", got, out_addr, ea); end
                            total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=0", got, out_err); end
                        end
                        ea = ea + 2'd1; got++;
                    end
                end
            end
        join
        total++; if (got != 10000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=10000", got); end
        out_ready = 0;
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] instr;
        logic        err;
        logic [1:0]  addr;
        do_reset;
        xfer(3, 0, 1, 2, 0, 32'h3, 1'b0, instr, err, addr);
        out_ready = 0;
        @(posedge clk); #1; set_req(0, 1, 0, 0, 0, 1); in_valid = 1;
        @(posedge clk); #1; set_req(0, 2, 0, 0, 0, 2);
        @(posedge clk); #1; in_valid = 0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        total++; if (err_count !== 2'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", err_count); end
        total++; if (out_addr !== 2'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d exp=0", out_addr); end
        @(posedge clk); #1; rst = 0;
        xfer(0, 3, 0, 0, 0, 3, 1'b0, instr, err, addr);
        total++; if (instr !== 32'h00300193) begin bad++; $display("FAIL mid_post_instr got=%h exp=00300193", instr); end
        total++; if (addr !== 2'd0) begin bad++; $display("FAIL mid_post_addr got=%0d exp=0", addr); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_latency;
        test_formats;
        test_imm_check;
        test_back_to_back;
        test_addr;
        test_random;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
